// File: rtl/wb_stage_pipelined_if.sv
// Bundle of signals between the memory stage and the writeback stage.
// The MEM side drives the in_* fields and observes the wb_* results.
// The WB stage consumes in_* and produces the register-file write port.
interface wb_stage_pipelined_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    localparam int LANE_W = $clog2(DATA_W / 8);

    logic                  in_valid;
    logic                  in_reg_write;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [1:0]            in_wb_sel;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_read_data;
    logic [DATA_W-1:0]     in_link_pc;
    logic [1:0]            in_load_size;
    logic                  in_load_unsigned;
    logic [LANE_W-1:0]     in_addr_low;

    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic [DATA_W-1:0]     wb_data;

    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
               in_read_data, in_link_pc, in_load_size, in_load_unsigned,
               in_addr_low,
        input  wb_valid, wb_reg_write, wb_dst, wb_data
    );

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
               in_read_data, in_link_pc, in_load_size, in_load_unsigned,
               in_addr_low,
        output wb_valid, wb_reg_write, wb_dst, wb_data
    );
endinterface

// File: rtl/wb_stage_pipelined.sv
// Writeback stage with its own MEM/WB pipeline register.
// Selects ALU, load or link result, extracts and extends sub-word loads,
// suppresses writes to register 0 and supports stall and flush.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_pipelined #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic stall,
    input  logic flush,
    wb_stage_pipelined_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_count
`endif
);
    localparam int LANE_W  = $clog2(DATA_W / 8);
    localparam int SHIFT_W = LANE_W + 3;

    logic                  validQ;
    logic                  regWriteQ;
    logic [REG_ADDR_W-1:0] rdQ;
    logic [1:0]            wbSelQ;
    logic [DATA_W-1:0]     aluResultQ;
    logic [DATA_W-1:0]     readDataQ;
    logic [DATA_W-1:0]     linkPcQ;
    logic [1:0]            loadSizeQ;
    logic                  loadUnsignedQ;
    logic [LANE_W-1:0]     addrLowQ;

    logic [SHIFT_W-1:0]    byteShift;
    logic [SHIFT_W-1:0]    halfShift;
    logic [SHIFT_W-1:0]    wordShift;
    logic [7:0]            byteSlice;
    logic [15:0]           halfSlice;
    logic [31:0]           wordSlice;
    logic [DATA_W-1:0]     loadData;
    logic [DATA_W-1:0]     resultData;

    // Pipeline register: flush kills the entry even while stalled, stall freezes everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            validQ        <= 1'b0;
            regWriteQ     <= 1'b0;
            rdQ           <= '0;
            wbSelQ        <= '0;
            aluResultQ    <= '0;
            readDataQ     <= '0;
            linkPcQ       <= '0;
            loadSizeQ     <= '0;
            loadUnsignedQ <= 1'b0;
            addrLowQ      <= '0;
        end else if (flush) begin
            validQ        <= 1'b0;
        end else if (!stall) begin
            validQ        <= bus.in_valid;
            regWriteQ     <= bus.in_reg_write;
            rdQ           <= bus.in_rd;
            wbSelQ        <= bus.in_wb_sel;
            aluResultQ    <= bus.in_alu_result;
            readDataQ     <= bus.in_read_data;
            linkPcQ       <= bus.in_link_pc;
            loadSizeQ     <= bus.in_load_size;
            loadUnsignedQ <= bus.in_load_unsigned;
            addrLowQ      <= bus.in_addr_low;
        end
    end

    // Little-endian lane extraction by shifting the lane down to bit 0, then extending.
    always_comb begin
        byteShift = {addrLowQ, 3'b000};
        halfShift = {addrLowQ[LANE_W-1:1], 4'b0000};
        wordShift = '0;
        if (DATA_W == 64) begin
            wordShift = {addrLowQ[LANE_W-1], {(LANE_W + 2){1'b0}}};
        end
        byteSlice = 8'(readDataQ >> byteShift);
        halfSlice = 16'(readDataQ >> halfShift);
        wordSlice = 32'(readDataQ >> wordShift);
        loadData  = readDataQ;
        case (loadSizeQ)
            2'd0: begin
                if (loadUnsignedQ) loadData = DATA_W'(byteSlice);
                else               loadData = DATA_W'($signed(byteSlice));
            end
            2'd1: begin
                if (loadUnsignedQ) loadData = DATA_W'(halfSlice);
                else               loadData = DATA_W'($signed(halfSlice));
            end
            2'd2: begin
                if (loadUnsignedQ) loadData = DATA_W'(wordSlice);
                else               loadData = DATA_W'($signed(wordSlice));
            end
            default: loadData = readDataQ;
        endcase
    end

    // Result select; driven even for invalid entries since the write enable gates it.
    always_comb begin
        resultData = aluResultQ;
        case (wbSelQ)
            2'd1:    resultData = loadData;
            2'd2:    resultData = linkPcQ;
            default: resultData = aluResultQ;
        endcase
    end

    assign bus.wb_valid     = validQ;
    assign bus.wb_dst       = rdQ;
    assign bus.wb_data      = resultData;
    assign bus.wb_reg_write = validQ & regWriteQ & (rdQ != '0) & ~stall;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retireCountQ;

    // Count entries leaving the stage; a flush only affects the incoming entry so it is ignored here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retireCountQ <= '0;
        end else if (validQ && !stall) begin
            retireCountQ <= retireCountQ + CNT_W'(1);
        end
    end

    assign retire_count = retireCountQ;
`endif
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Self-checking bench for wb_stage_pipelined: one 32-bit and one 64-bit instance
// driven with the same stimulus, a behavioural model, and directed literal checks.
module tb_wb_stage_pipelined;
    logic clock;
    logic reset_n;
    logic stallIn;
    logic flushIn;

    logic        inValid;
    logic        inRegWrite;
    logic [4:0]  inRd;
    logic [1:0]  inWbSel;
    logic [63:0] inAlu;
    logic [63:0] inReadData;
    logic [63:0] inLinkPc;
    logic [1:0]  inLoadSize;
    logic        inLoadUnsigned;
    logic [2:0]  inAddrLow;

    int checks;
    int errors;

    wb_stage_pipelined_if #(.DATA_W(32), .REG_ADDR_W(5)) bus32 ();
    wb_stage_pipelined_if #(.DATA_W(64), .REG_ADDR_W(5)) bus64 ();

`ifdef WB_RETIRE_CNT_EN
    logic [3:0] retireCount32;
    logic [3:0] retireCount64;
`endif

    wb_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut32 (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stallIn),
        .flush(flushIn),
        .bus(bus32)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count(retireCount32)
`endif
    );

    wb_stage_pipelined #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) dut64 (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stallIn),
        .flush(flushIn),
        .bus(bus64)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count(retireCount64)
`endif
    );

    assign bus32.in_valid         = inValid;
    assign bus32.in_reg_write     = inRegWrite;
    assign bus32.in_rd            = inRd;
    assign bus32.in_wb_sel        = inWbSel;
    assign bus32.in_alu_result    = inAlu[31:0];
    assign bus32.in_read_data     = inReadData[31:0];
    assign bus32.in_link_pc       = inLinkPc[31:0];
    assign bus32.in_load_size     = inLoadSize;
    assign bus32.in_load_unsigned = inLoadUnsigned;
    assign bus32.in_addr_low      = inAddrLow[1:0];

    assign bus64.in_valid         = inValid;
    assign bus64.in_reg_write     = inRegWrite;
    assign bus64.in_rd            = inRd;
    assign bus64.in_wb_sel        = inWbSel;
    assign bus64.in_alu_result    = inAlu;
    assign bus64.in_read_data     = inReadData;
    assign bus64.in_link_pc       = inLinkPc;
    assign bus64.in_load_size     = inLoadSize;
    assign bus64.in_load_unsigned = inLoadUnsigned;
    assign bus64.in_addr_low      = inAddrLow;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] link;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  addr;
    } entry_t;

    entry_t modelEntry = '0;
    int     expCount   = 0;

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected write data for a datapath of width w, from plain arithmetic on the entry.
    function automatic logic [63:0] expData(entry_t e, int w);
        logic [63:0] mask;
        logic [63:0] rdv;
        logic [63:0] v;
        logic [63:0] one;
        int          lane;
        int          bits;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rdv  = e.rdata & mask;
        lane = int'(e.addr) % (w / 8);
        one  = 64'd1;
        if (e.sel == 2'd2) return e.link & mask;
        if (e.sel != 2'd1) return e.alu & mask;
        case (e.size)
            2'd0: begin v = (rdv >> (8 * lane)) & 64'hFF; bits = 8; end
            2'd1: begin v = (rdv >> (16 * (lane / 2))) & 64'hFFFF; bits = 16; end
            2'd2: begin
                if (w == 64) v = (rdv >> (32 * (lane / 4))) & 64'hFFFF_FFFF;
                else         v = rdv;
                bits = 32;
            end
            default: return rdv;
        endcase
        if (!e.uns && v[bits-1]) v = v | ~((one << bits) - 64'd1);
        return v & mask;
    endfunction

    // Model of the stage: what is held after each edge and how many entries have left it.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            modelEntry = '0;
            expCount   = 0;
        end else begin
            if (modelEntry.valid && !stallIn) expCount = (expCount + 1) % 16;
            if (flushIn) begin
                modelEntry.valid = 1'b0;
            end else if (!stallIn) begin
                modelEntry = '{inValid, inRegWrite, inRd, inWbSel, inAlu, inReadData,
                               inLinkPc, inLoadSize, inLoadUnsigned, inAddrLow};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare both instances against the model every cycle, away from the rising edge.
    always @(negedge clock) begin
        logic expWrite;
        expWrite = modelEntry.valid && modelEntry.regWrite && (modelEntry.rd != 5'd0) && !stallIn;
        checkOutput("model valid32", 64'(bus32.wb_valid), 64'(modelEntry.valid));
        checkOutput("model write32", 64'(bus32.wb_reg_write), 64'(expWrite));
        checkOutput("model dst32", 64'(bus32.wb_dst), 64'(modelEntry.rd));
        checkOutput("model data32", 64'(bus32.wb_data), expData(modelEntry, 32));
        checkOutput("model valid64", 64'(bus64.wb_valid), 64'(modelEntry.valid));
        checkOutput("model write64", 64'(bus64.wb_reg_write), 64'(expWrite));
        checkOutput("model dst64", 64'(bus64.wb_dst), 64'(modelEntry.rd));
        checkOutput("model data64", bus64.wb_data, expData(modelEntry, 64));
`ifdef WB_RETIRE_CNT_EN
        checkOutput("model retire32", 64'(retireCount32), 64'(expCount));
        checkOutput("model retire64", 64'(retireCount64), 64'(expCount));
`endif
    end

    // Present one MEM-stage entry, then land just after the edge that captured it.
    task automatic applyStimulus(input logic valid, input logic regWrite, input logic [4:0] rd,
                                 input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] rdata,
                                 input logic [63:0] link, input logic [1:0] size, input logic uns,
                                 input logic [2:0] addr);
        inValid        = valid;
        inRegWrite     = regWrite;
        inRd           = rd;
        inWbSel        = sel;
        inAlu          = alu;
        inReadData     = rdata;
        inLinkPc       = link;
        inLoadSize     = size;
        inLoadUnsigned = uns;
        inAddrLow      = addr;
        @(negedge clock);
        #1;
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        stallIn = 1'b0;
        flushIn = 1'b0;
        inValid = 1'b0; inRegWrite = 1'b0; inRd = '0; inWbSel = '0;
        inAlu = '0; inReadData = '0; inLinkPc = '0; inLoadSize = '0;
        inLoadUnsigned = 1'b0; inAddrLow = '0;

        repeat (2) @(negedge clock);
        #1;
        checkOutput("reset valid", 64'(bus32.wb_valid), 64'd0);
        checkOutput("reset write", 64'(bus32.wb_reg_write), 64'd0);
        checkOutput("reset dst", 64'(bus32.wb_dst), 64'd0);
        checkOutput("reset data", 64'(bus32.wb_data), 64'd0);
        reset_n = 1'b1;

        applyStimulus(1, 1, 5, 0, 64'h1234_5678, 0, 0, 2, 0, 0);
        checkOutput("alu write", 64'(bus32.wb_reg_write), 64'd1);
        checkOutput("alu dst", 64'(bus32.wb_dst), 64'd5);
        checkOutput("alu data", 64'(bus32.wb_data), 64'h1234_5678);

        applyStimulus(1, 1, 3, 1, 0, 64'h0080_FF00, 0, 0, 0, 2);
        checkOutput("lb signed32", 64'(bus32.wb_data), 64'hFFFF_FF80);
        checkOutput("lb signed64", bus64.wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        applyStimulus(1, 1, 3, 1, 0, 64'h0080_FF00, 0, 0, 1, 2);
        checkOutput("lb unsigned32", 64'(bus32.wb_data), 64'h0000_0080);

        applyStimulus(1, 1, 4, 1, 0, 64'h8001_0000, 0, 1, 0, 2);
        checkOutput("lh signed32", 64'(bus32.wb_data), 64'hFFFF_8001);
        applyStimulus(1, 1, 6, 1, 0, 64'h8000_0000_0000_0001, 0, 2, 0, 4);
        checkOutput("lw upper64", bus64.wb_data, 64'hFFFF_FFFF_8000_0000);
        checkOutput("lw low32", 64'(bus32.wb_data), 64'h0000_0001);
        applyStimulus(1, 1, 6, 1, 0, 64'h8000_0000_0000_0001, 0, 3, 0, 4);
        checkOutput("ld full64", bus64.wb_data, 64'h8000_0000_0000_0001);

        applyStimulus(1, 1, 0, 0, 64'hDEAD, 0, 0, 0, 0, 0);
        checkOutput("r0 write", 64'(bus32.wb_reg_write), 64'd0);
        checkOutput("r0 valid", 64'(bus32.wb_valid), 64'd1);
        applyStimulus(1, 1, 31, 2, 0, 0, 64'h0040_0008, 0, 0, 0);
        checkOutput("link data", 64'(bus32.wb_data), 64'h0040_0008);
        checkOutput("link dst", 64'(bus32.wb_dst), 64'd31);
        checkOutput("link write", 64'(bus32.wb_reg_write), 64'd1);

        applyStimulus(1, 1, 7, 0, 64'hAAAA_5555, 0, 0, 0, 0, 0);
        checkOutput("prestall write", 64'(bus32.wb_reg_write), 64'd1);
        stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 9, 0, 64'h1111_1111, 0, 0, 0, 0, 0);
            checkOutput("stall write", 64'(bus32.wb_reg_write), 64'd0);
            checkOutput("stall data", 64'(bus32.wb_data), 64'hAAAA_5555);
            checkOutput("stall dst", 64'(bus32.wb_dst), 64'd7);
        end
        stallIn = 1'b0;
        inValid = 1'b0;
        #1;
        checkOutput("release write", 64'(bus32.wb_reg_write), 64'd1);
        @(negedge clock);
        #1;
        checkOutput("after release write", 64'(bus32.wb_reg_write), 64'd0);

        applyStimulus(1, 1, 8, 0, 64'h42, 0, 0, 0, 0, 0);
        checkOutput("preflush valid", 64'(bus32.wb_valid), 64'd1);
        stallIn = 1'b1;
        flushIn = 1'b1;
        applyStimulus(1, 1, 10, 0, 64'h43, 0, 0, 0, 0, 0);
        checkOutput("flush valid", 64'(bus32.wb_valid), 64'd0);
        checkOutput("flush write", 64'(bus32.wb_reg_write), 64'd0);
        stallIn = 1'b0;
        flushIn = 1'b0;

`ifdef WB_RETIRE_CNT_EN
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 1, 5'(i + 1), 0, 64'(i), 0, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("retire wrap32", 64'(retireCount32), 64'd1);
        checkOutput("retire wrap64", 64'(retireCount64), 64'd1);
`endif

        applyStimulus(1, 1, 12, 0, 64'h77, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset valid", 64'(bus32.wb_valid), 64'd0);
        checkOutput("async reset dst", 64'(bus32.wb_dst), 64'd0);
        checkOutput("async reset data", 64'(bus64.wb_data), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("async reset retire", 64'(retireCount32), 64'd0);
`endif
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        applyStimulus(1, 1, 2, 0, 64'h99, 0, 0, 0, 0, 0);
        checkOutput("post reset data", 64'(bus32.wb_data), 64'h99);

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
